// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
//   arb_state_t        : arbiter FSM states (IDLE waits for a request, BUSY owns the slave)
//   idx_width()        : number of bits needed to hold a port index
//   DEFAULT_ERROR_DATA : read data handed back when a transaction times out
package mem_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam logic [31:0] DEFAULT_ERROR_DATA = 32'hDEADBEEF;

  // A single port still needs a 1-bit index so vectors never collapse to zero width.
  function automatic int idx_width(input int n);
    if (n < 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   i_req   : request vector, one bit per port
//   i_ptr   : port with highest priority this round
//   o_grant : first requesting port at or after i_ptr, wrapping modulo NUM_PORTS
//   o_valid : at least one port is requesting
module rr_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_ptr,
  output logic [IDX_W-1:0]     o_grant,
  output logic                 o_valid
);

  logic [IDX_W-1:0] w_idx;

  // Scan from the farthest offset down to offset 0 so the requester
  // closest to the pointer is the last one written and therefore wins.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int off = NUM_PORTS - 1; off >= 0; off--) begin
      w_idx = IDX_W'((int'(i_ptr) + off) % NUM_PORTS);
      if (i_req[w_idx]) begin
        o_grant = w_idx;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-master to 1-slave memory port arbiter with round-robin fairness,
// request latching, per-port error pulse and optional bus timeout.
//   clk, reset          : single clock, synchronous active-high reset
//   port_read/write     : per-master request strobes, held until port_response
//   port_address        : packed, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   port_write_data     : packed, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   port_read_data      : packed registered read data per master
//   port_response       : one-cycle completion pulse per master
//   port_error          : one-cycle pulse with port_response on a timed-out transaction
//   mem_read/mem_write  : registered slave strobes, held for the whole transaction
//   mem_address         : registered slave address
//   mem_write_data      : registered slave write data
//   mem_read_data       : slave read data, valid with mem_response
//   mem_response        : slave completion pulse
//   dbg_state           : current FSM state (0 = IDLE, 1 = BUSY)
//
// Handshake: a master raises read or write and keeps address/data stable until
// it sees its port_response pulse; the arbiter latches everything at grant time
// and ignores the master inputs until completion. The slave sees a held strobe
// and ends the transaction with a single-cycle mem_response.
module mem_port_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0,
  parameter logic [DATA_WIDTH-1:0] ERROR_DATA = DATA_WIDTH'(DEFAULT_ERROR_DATA)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             port_read,
  input  logic [NUM_PORTS-1:0]             port_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_write_data,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  port_read_data,
  output logic [NUM_PORTS-1:0]             port_response,
  output logic [NUM_PORTS-1:0]             port_error,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]            mem_write_data,
  input  logic [DATA_WIDTH-1:0]            mem_read_data,
  input  logic                             mem_response,
  output logic                             dbg_state
);

  localparam int          IDX_W        = idx_width(NUM_PORTS);
  localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

  arb_state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_grant, w_grant_nxt;
  logic [IDX_W-1:0]       r_ptr, w_ptr_nxt;
  logic [31:0]            r_cnt, w_cnt_nxt;
  logic                   r_mem_read, w_mem_read_nxt;
  logic                   r_mem_write, w_mem_write_nxt;
  logic [ADDR_WIDTH-1:0]  r_mem_addr, w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0]  r_mem_wdata, w_mem_wdata_nxt;
  logic [NUM_PORTS-1:0]   r_resp, w_resp_nxt;
  logic [NUM_PORTS-1:0]   r_err, w_err_nxt;
  logic [DATA_WIDTH-1:0]  r_rdata     [NUM_PORTS];
  logic [DATA_WIDTH-1:0]  w_rdata_nxt [NUM_PORTS];

  logic [ADDR_WIDTH-1:0]  w_addr_arr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0]  w_wdata_arr [NUM_PORTS];
  logic [NUM_PORTS-1:0]   w_req;
  logic [IDX_W-1:0]       w_arb_idx;
  logic                   w_arb_valid;
  logic                   w_timeout_hit;

  // Unpack the flat master buses into per-port views.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ports
    assign w_addr_arr[g]  = port_address[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata_arr[g] = port_write_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign port_read_data[g*DATA_WIDTH +: DATA_WIDTH] = r_rdata[g];
  end

  assign w_req = port_read | port_write;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_arbiter (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  // r_cnt counts BUSY cycles already spent, so the last allowed cycle is
  // the one where it equals TIMEOUT_CYCLES-1.
  assign w_timeout_hit = TIMEOUT_EN && (r_cnt == TIMEOUT_LAST);

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_ptr_nxt       = r_ptr;
    w_cnt_nxt       = r_cnt;
    w_mem_read_nxt  = r_mem_read;
    w_mem_write_nxt = r_mem_write;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_resp_nxt      = '0;
    w_err_nxt       = '0;
    w_rdata_nxt     = r_rdata;
    case (r_state)
      IDLE: begin
        if (w_arb_valid) begin
          w_grant_nxt     = w_arb_idx;
          w_mem_addr_nxt  = w_addr_arr[w_arb_idx];
          w_mem_wdata_nxt = w_wdata_arr[w_arb_idx];
          // Write takes precedence when a master raises both strobes.
          w_mem_write_nxt = port_write[w_arb_idx];
          w_mem_read_nxt  = port_read[w_arb_idx] & ~port_write[w_arb_idx];
          w_cnt_nxt       = 32'd0;
          w_state_nxt     = BUSY;
        end
      end
      BUSY: begin
        // A response on the timeout cycle still counts as a clean completion.
        if (mem_response || w_timeout_hit) begin
          w_resp_nxt[r_grant] = 1'b1;
          w_err_nxt[r_grant]  = ~mem_response;
          if (r_mem_read) begin
            w_rdata_nxt[r_grant] = mem_response ? mem_read_data : ERROR_DATA;
          end
          w_mem_read_nxt  = 1'b0;
          w_mem_write_nxt = 1'b0;
          w_ptr_nxt       = (r_grant == LAST_PORT) ? '0 : r_grant + 1'b1;
          w_state_nxt     = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_ptr       <= '0;
      r_cnt       <= 32'd0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_resp      <= '0;
      r_err       <= '0;
      r_rdata     <= '{default: '0};
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_resp      <= w_resp_nxt;
      r_err       <= w_err_nxt;
      r_rdata     <= w_rdata_nxt;
    end
  end

  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_address    = r_mem_addr;
  assign mem_write_data = r_mem_wdata;
  assign port_response  = r_resp;
  assign port_error     = r_err;
  assign dbg_state      = logic'(r_state);

endmodule
